alu_share_ctrl: RTL

Controller that time-shares one instance of the team's 32-bit `alu` between two requesters, for example the EX stage and a branch/address unit. It arbitrates between the two requests and latches the winner's operands. It sequences the operation through the ALU and returns a registered result and zero flag on the winner's response channel. Both the request and response channels use a valid/ready handshake.

---
 rtl/alu_share_ctrl_pkg.sv | 23 ++
 rtl/alu.sv | 40 ++++
 rtl/alu_share_ctrl_arb2_rr.sv | 41 ++++
 rtl/alu_share_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: FSM state encoding and
// ALU op codes. Build option ALU_SHARE_RR_EN selects round-robin arbitration
// in arb2_rr (fixed priority to requester 0 when undefined).
package alu_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit 3 only matters for the shift group; elsewhere it is don't-care.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU shared by the controller. Shifts move b by the
// full value of a, so amounts >= WIDTH flush to zero (or sign for SRA).
// Not affected by ALU_SHARE_RR_EN.
module alu
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] s,
    output logic             z
);

    // Op decode: exact match for the shift group, low 3 bits for the rest.
    always_comb begin
        s = '0;
        if (aluc == ALU_SLL)
            s = b << a;
        else if (aluc == ALU_SRL)
            s = b >> a;
        else if (aluc == ALU_SRA)
            s = $signed(b) >>> a;
        else begin
            case (aluc[2:0])
                ALU_ADD[2:0]: s = a + b;
                ALU_SUB[2:0]: s = a - b;
                ALU_AND[2:0]: s = a & b;
                ALU_OR[2:0]:  s = a | b;
                ALU_XOR[2:0]: s = a ^ b;
                ALU_LUI[2:0]: s = a << 16;
                default:      s = '0;
            endcase
        end
    end

    assign z = (s == '0);

endmodule

// File: rtl/alu_share_ctrl_arb2_rr.sv
// Two-way arbiter. With ALU_SHARE_RR_EN defined a contest goes to the
// requester not served last (pointer resets to 1, so requester 0 wins first);
// otherwise requester 0 always wins a contest and no pointer is kept.
module arb2_rr (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,   // current grant is being consumed this cycle
    output logic [1:0] grant
);

`ifdef ALU_SHARE_RR_EN
    logic last;

    // Remember who was served so the other side wins the next contest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last <= 1'b1;
        else if (take)
            last <= grant[1];
    end

    // Single request wins outright; a contest goes to the one not served last.
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clock, reset, take};

    // Fixed priority: requester 0 wins any contest.
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = 2'b01;
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one alu between two valid/ready requesters. IDLE accepts one
// request, EXEC captures the ALU result, RESP presents it on the winner's
// response channel until taken. ALU_SHARE_RR_EN selects round-robin
// arbitration (see arb2_rr); default is fixed priority to requester 0.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_aluc,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_z,
    output logic             busy
);

    state_t           state;
    logic             gid;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       op_c;
    logic [1:0]       rsp_vld;
    logic [1:0]       grant;
    logic             take;
    logic [WIDTH-1:0] alu_s;
    logic             alu_z;

    arb2_rr u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .take  (take),
        .grant (grant)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .a    (op_a),
        .b    (op_b),
        .aluc (op_c),
        .s    (alu_s),
        .z    (alu_z)
    );

    // Ready only in IDLE and only for the grantee; held low while in reset.
    assign take       = (state == IDLE) && !reset && (grant != 2'b00);
    assign req0_ready = take && grant[0];
    assign req1_ready = take && grant[1];
    assign rsp0_valid = rsp_vld[0];
    assign rsp1_valid = rsp_vld[1];

    // Controller FSM with registered result, response valids and busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gid     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_c    <= '0;
            rsp_s   <= '0;
            rsp_z   <= 1'b0;
            rsp_vld <= 2'b00;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        gid   <= grant[1];
                        op_a  <= grant[1] ? req1_a    : req0_a;
                        op_b  <= grant[1] ? req1_b    : req0_b;
                        op_c  <= grant[1] ? req1_aluc : req0_aluc;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_s   <= alu_s;
                    rsp_z   <= alu_z;
                    rsp_vld <= gid ? 2'b10 : 2'b01;
                    state   <= RESP;
                end
                RESP: begin
                    if ((rsp_vld & {rsp1_ready, rsp0_ready}) != 2'b00) begin
                        rsp_vld <= 2'b00;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
